// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - state type and widths shared by the Genius game controller
package genius_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    INIT       = 3'd0,
    SETUP      = 3'd1,
    SEQUENCE   = 3'd2,
    PLAY       = 3'd3,
    CHECK      = 3'd4,
    NEXT_ROUND = 3'd5,
    RESULT     = 3'd6
  } state_t;

endpackage

// File: rtl/genius_if.sv
// rtl/genius_if.sv - control/status bundle between the game controller and datapath
interface genius_if;
  import genius_pkg::*;

  logic               R1;
  logic               R2;
  logic               E1;
  logic               E2;
  logic               E3;
  logic               E4;
  logic               SEL;
  logic [STATE_W-1:0] state_o;
  logic               end_FPGA;
  logic               end_User;
  logic               end_time;
  logic               win;
  logic               match;

  modport master (
    output R1, R2, E1, E2, E3, E4, SEL, state_o,
    input  end_FPGA, end_User, end_time, win, match
  );

  modport slave (
    input  R1, R2, E1, E2, E3, E4, SEL, state_o,
    output end_FPGA, end_User, end_time, win, match
  );
endinterface

// File: rtl/genius_key_press_detect.sv
// rtl/genius_key_press_detect.sv - confirm-key synchroniser and one-cycle press pulse
module key_press_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   key_prev;
  logic                   press_q;

  // Everything resets to "released" so reset release never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '1;
      key_prev <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], key_n};
      key_prev <= sync[SYNC_STAGES-1];
      press_q  <= key_prev & ~sync[SYNC_STAGES-1];
    end
  end

  assign press = press_q;

endmodule

// File: rtl/genius_controller.sv
// rtl/genius_controller.sv - Moore sequencing FSM for the Genius memory game
module genius_controller
  import genius_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     CLOCK_50,
  input  logic     reset,
  input  logic     KEY_ENTER,
  genius_if.master dp
);

  state_t state;
  state_t next_state;
  logic   press;

  key_press_detect #(.SYNC_STAGES(SYNC_STAGES)) u_key (
    .clk   (CLOCK_50),
    .rst_n (reset),
    .key_n (KEY_ENTER),
    .press (press)
  );

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state <= INIT;
    else        state <= next_state;
  end

  // end_User has priority over end_time when both arrive together.
  always_comb begin
    next_state = state;
    case (state)
      INIT:       next_state = SETUP;
      SETUP:      if (press) next_state = SEQUENCE;
      SEQUENCE:   if (dp.end_FPGA) next_state = PLAY;
      PLAY: begin
        if (dp.end_User)      next_state = CHECK;
        else if (dp.end_time) next_state = RESULT;
      end
      CHECK:      next_state = (dp.match && !dp.win) ? NEXT_ROUND : RESULT;
      NEXT_ROUND: next_state = SEQUENCE;
      RESULT:     if (press) next_state = INIT;
      default:    next_state = INIT;
    endcase
  end

  always_comb begin
    dp.R1  = 1'b0;
    dp.R2  = 1'b0;
    dp.E1  = 1'b0;
    dp.E2  = 1'b0;
    dp.E3  = 1'b0;
    dp.E4  = 1'b0;
    dp.SEL = 1'b1;
    case (state)
      INIT: begin
        dp.R1 = 1'b1;
        dp.R2 = 1'b1;
      end
      SETUP:    dp.E1 = 1'b1;
      SEQUENCE: dp.E3 = 1'b1;
      PLAY:     dp.E2 = 1'b1;
      CHECK:    ;
      NEXT_ROUND: begin
        dp.E4 = 1'b1;
        dp.R2 = 1'b1;
      end
      default:  dp.SEL = 1'b0;
    endcase
  end

  assign dp.state_o = state;

endmodule

// File: tb/tb_genius_controller.sv
// tb/tb_genius_controller.sv - self-checking bench for genius_controller
module tb_genius_controller;

  localparam int S_INIT = 0, S_SETUP = 1, S_SEQ = 2, S_PLAY = 3;
  localparam int S_CHECK = 4, S_NEXT = 5, S_RESULT = 6;

  typedef struct {
    logic key;
    logic fpga;
    logic user;
    logic tm;
    logic w;
    logic m;
    int   exp_state;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic key_enter;
  int   tests = 0;
  int   fails = 0;

  genius_if bus();

  genius_controller #(.SYNC_STAGES(2)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .KEY_ENTER (key_enter),
    .dp        (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] outs;
  assign outs = {bus.R1, bus.R2, bus.E1, bus.E2, bus.E3, bus.E4, bus.SEL};

  // Output pattern {R1,R2,E1,E2,E3,E4,SEL} for each state.
  function automatic logic [6:0] exp_outs(input int s);
    case (s)
      S_INIT:  return 7'b1100001;
      S_SETUP: return 7'b0010001;
      S_SEQ:   return 7'b0000101;
      S_PLAY:  return 7'b0001001;
      S_CHECK: return 7'b0000001;
      S_NEXT:  return 7'b0100011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got state/outs %h, expected %h", name, got, exp);
    end
  endtask

  task automatic chk_state(input string name, input int s);
    chk(name, {bus.state_o, outs}, {3'(s), exp_outs(s)});
  endtask

  task automatic drive(input logic k, input logic f, input logic u, input logic t,
                       input logic w, input logic m);
    key_enter    = k;
    bus.end_FPGA = f;
    bus.end_User = u;
    bus.end_time = t;
    bus.win      = w;
    bus.match    = m;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_chk(input string name, input int s);
    cyc();
    chk_state(name, s);
  endtask

  vec_t tbl[$];

  task automatic add(input logic k, input logic f, input logic u, input logic t,
                     input logic w, input logic m, input int s);
    vec_t v;
    v.key = k; v.fpga = f; v.user = u; v.tm = t; v.w = w; v.m = m; v.exp_state = s;
    tbl.push_back(v);
  endtask

  // Reference model state: spec-level transition rules plus a key sample history.
  int   ms;
  logic h1, h2, h3, h4;

  function automatic int model_next(input int s, input logic pulse);
    if (s == S_INIT)   return S_SETUP;
    if (s == S_SETUP)  return pulse ? S_SEQ : S_SETUP;
    if (s == S_SEQ)    return bus.end_FPGA ? S_PLAY : S_SEQ;
    if (s == S_PLAY)   return bus.end_User ? S_CHECK : (bus.end_time ? S_RESULT : S_PLAY);
    if (s == S_CHECK)  return (bus.match && !bus.win) ? S_NEXT : S_RESULT;
    if (s == S_NEXT)   return S_SEQ;
    return pulse ? S_INIT : S_RESULT;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_edge;
    int changes;
    int prev_s;
    logic pulse;

    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    #2;
    chk_state("reset_before_clock", S_INIT);
    cyc();
    cyc();
    reset = 1'b1;

    // Scripted game walk: key presses need three low samples, state moves on the fourth edge.
    add(1,0,0,0,0,0, S_SETUP);
    add(0,0,0,0,0,0, S_SETUP);
    add(0,0,0,0,0,0, S_SETUP);
    add(0,0,0,0,0,0, S_SETUP);
    add(1,0,0,0,0,0, S_SEQ);
    add(1,0,0,0,0,0, S_SEQ);
    add(1,1,0,0,0,0, S_PLAY);
    add(1,0,0,0,0,0, S_PLAY);
    add(1,0,1,0,0,1, S_CHECK);
    add(1,0,0,0,0,1, S_NEXT);
    add(1,0,0,0,0,0, S_SEQ);
    add(1,1,0,0,0,0, S_PLAY);
    add(1,0,1,1,0,0, S_CHECK);
    add(1,0,0,0,1,0, S_RESULT);
    add(1,0,0,0,0,0, S_RESULT);
    add(0,0,0,0,0,0, S_RESULT);
    add(0,0,0,0,0,0, S_RESULT);
    add(0,0,0,0,0,0, S_RESULT);
    add(1,0,0,0,0,0, S_INIT);
    add(1,0,0,0,0,0, S_SETUP);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].key, tbl[i].fpga, tbl[i].user, tbl[i].tm, tbl[i].w, tbl[i].m);
      cyc_chk($sformatf("table_%0d", i), tbl[i].exp_state);
    end

    // Held key: exactly one transition, on the fourth edge.
    drive(0, 0, 0, 0, 0, 0);
    first_edge = 0;
    changes    = 0;
    prev_s     = S_SETUP;
    for (int e = 1; e <= 12; e++) begin
      cyc();
      if (int'(bus.state_o) != prev_s) begin
        changes++;
        if (first_edge == 0) first_edge = e;
      end
      prev_s = int'(bus.state_o);
    end
    tests++;
    if (first_edge != 4) begin
      fails++;
      $display("FAIL hold_latency: got edge %0d, expected 4", first_edge);
    end
    tests++;
    if (changes != 1) begin
      fails++;
      $display("FAIL hold_single: got %0d transitions, expected 1", changes);
    end
    chk_state("hold_state", S_SEQ);

    // Final win then exit result screen.
    drive(1, 1, 0, 0, 0, 0);
    cyc_chk("win_play", S_PLAY);
    drive(1, 0, 1, 0, 0, 0);
    cyc_chk("win_check", S_CHECK);
    drive(1, 0, 0, 0, 1, 1);
    cyc_chk("win_result", S_RESULT);
    drive(0, 0, 0, 0, 0, 0);
    cyc(); cyc(); cyc();
    drive(1, 0, 0, 0, 0, 0);
    cyc_chk("win_exit", S_INIT);

    // Timeout alone, then mid-game asynchronous reset from PLAY.
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    cyc(); cyc(); cyc();
    drive(1, 0, 0, 0, 0, 0);
    cyc_chk("to_seq", S_SEQ);
    drive(1, 1, 0, 0, 0, 0);
    cyc_chk("to_play", S_PLAY);
    drive(1, 0, 0, 1, 0, 0);
    cyc_chk("timeout_result", S_RESULT);
    drive(0, 0, 0, 0, 0, 0);
    cyc(); cyc(); cyc();
    drive(1, 0, 0, 0, 0, 0);
    cyc(); cyc();
    drive(0, 0, 0, 0, 0, 0);
    cyc(); cyc(); cyc();
    drive(1, 1, 0, 0, 0, 0);
    cyc(); cyc();
    chk_state("midreset_pre", S_PLAY);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_state("midreset_async", S_INIT);
    cyc();
    reset = 1'b1;

    // Randomised run against the reference model.
    ms = S_INIT;
    h1 = 1'b1; h2 = 1'b1; h3 = 1'b1; h4 = 1'b1;
    key_enter = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63) == 0) begin
        reset = 1'b0;
        #1;
        ms = S_INIT;
        h1 = 1'b1; h2 = 1'b1; h3 = 1'b1; h4 = 1'b1;
        chk_state("rand_reset", ms);
        reset = 1'b1;
      end
      if ($urandom_range(7) == 0) key_enter = ~key_enter;
      bus.end_FPGA = ($urandom_range(2) == 0);
      bus.end_User = ($urandom_range(2) == 0);
      bus.end_time = ($urandom_range(2) == 0);
      bus.win      = ($urandom_range(2) == 0);
      bus.match    = ($urandom_range(2) == 0);
      @(posedge clk);
      pulse = !h3 && h4;
      ms    = model_next(ms, pulse);
      h4 = h3; h3 = h2; h2 = h1; h1 = key_enter;
      #1;
      chk_state($sformatf("rand_%0d", i), ms);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/genius_controller.md
# genius_controller

Control FSM for the Genius memory game; it sits on the other side of the game datapath's control/status interface. It drives the datapath's reset, enable and display-select strobes (R1, R2, E1–E4, SEL) and sequences the game from the status flags the datapath returns (end_FPGA, end_User, end_time, win, match). It also synchronises and edge-detects the player's confirm key, used to start a game and to leave the result screen.

## Interface

Parameters:
- SYNC_STAGES, 2: flip-flop stages on the confirm-key synchroniser; legal values are 2 or more.

Ports:
- CLOCK_50  in  1  system clock; every register is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- KEY_ENTER  in  1  raw confirm key, active-low (pressed = 0).
- end_FPGA  in  1  datapath status: FPGA sequence playback complete.
- end_User  in  1  datapath status: player has entered ROUND keys.
- end_time  in  1  datapath status: input time limit expired.
- win  in  1  datapath status: current round is the final round.
- match  in  1  datapath status: player sequence equals FPGA sequence.
- R1  out  1  global datapath reset (setup and round registers).
- R2  out  1  per-round datapath reset (time, user, FPGA counters and registers).
- E1  out  1  setup register load enable.
- E2  out  1  time counter / user input enable.
- E3  out  1  FPGA sequence counter / register enable.
- E4  out  1  round counter increment.
- SEL  out  1  display select: 1 = game screen, 0 = result screen.
- state_o  out  3  current state encoding, for debug.

## Operation

- Moore FSM; all outputs decode from the state register only.
- States and outputs (unlisted outputs are 0):
  - INIT: R1=1, R2=1, SEL=1.
  - SETUP: E1=1, SEL=1.
  - SEQUENCE: E3=1, SEL=1.
  - PLAY: E2=1, SEL=1.
  - CHECK: SEL=1.
  - NEXT_ROUND: E4=1, R2=1, SEL=1.
  - RESULT: SEL=0.
- Transitions:
  - INIT → SETUP, unconditionally after 1 cycle.
  - SETUP → SEQUENCE on a press pulse; otherwise hold.
  - SEQUENCE → PLAY when end_FPGA=1.
  - PLAY → CHECK when end_User=1. Otherwise PLAY → RESULT when end_time=1. If both are 1 in the same cycle, end_User wins and the next state is CHECK.
  - CHECK: match=1 and win=1 → RESULT. match=1 and win=0 → NEXT_ROUND. match=0 → RESULT. The decision is made in a single cycle.
  - NEXT_ROUND → SEQUENCE, unconditionally after 1 cycle.
  - RESULT → INIT on a press pulse; otherwise hold.
- Press pulse:
  - KEY_ENTER passes through SYNC_STAGES flip-flops, then a falling-edge detector.
  - Each 1→0 transition of the synchronised key produces exactly one 1-cycle pulse. Holding the key low produces no further pulses.
  - Pulses outside SETUP and RESULT are ignored.
- Status inputs are synchronous to CLOCK_50 and are not re-synchronised.

## Timing

- Reset asserted (reset=0): state=INIT immediately, without waiting for a clock edge.
  - Outputs become R1=1, R2=1, SEL=1, E1=E2=E3=E4=0, state_o=INIT.
  - Synchroniser flops reset to 1 (key released) and the edge register resets to 1, so no spurious pulse follows reset release.
- Reset asserted mid-game, in any state, behaves identically; it overrides any pending transition.
- The first clock edge after reset release moves INIT → SETUP.
- Status-driven transitions take effect on the clock edge that samples the condition; outputs change in the same cycle as the new state.
- Press latency: KEY_ENTER falling at edge n produces the pulse at cycle n+SYNC_STAGES+1. The state changes at the following edge.
- E4 and R2 are each high for exactly one cycle per completed round.

## Structure

- Package genius_pkg holds:
  - The state type and encodings: INIT=0, SETUP=1, SEQUENCE=2, PLAY=3, CHECK=4, NEXT_ROUND=5, RESULT=6.
  - The STATE_W=3 constant.
- One sub-module, key_press_detect: the synchroniser plus falling-edge pulse, parameterised by SYNC_STAGES, with asynchronous active-low reset.
- The top level contains a next-state process, a state register and the output decode.

## Test plan

- Reset: reset=0 → outputs R1=1, R2=1, SEL=1, E1–E4=0 before any clock. After release, one edge → state_o=1 with E1=1.
- Start: in SETUP, KEY_ENTER low for 10 cycles → exactly one transition to SEQUENCE (E3=1), 4 edges after the key falls (SYNC_STAGES=2). No second transition while the key is held.
- Winning round: SEQUENCE with end_FPGA=1 → PLAY (E2=1). Then end_User=1, match=1, win=0 → CHECK, then NEXT_ROUND with E4=R2=1 for exactly 1 cycle, then SEQUENCE.
- Final win: in CHECK with match=1, win=1 → RESULT (SEL=0). A press pulse → INIT (R1=1).
- Timeout and tie: in PLAY, end_time=1 alone → RESULT. end_time=1 and end_User=1 together → CHECK. From CHECK, match=0 → RESULT.
- Mid-game reset: assert reset=0 in PLAY with E2=1 → E2=0 and R1=R2=1 asynchronously, state_o=0.
